// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point add/subtract (RNE/RTZ/RUP/RDN, subnormals). Result valid 5 edges after accept (2 for NaN/Inf).
// One op in flight: In_ready only in IDLE; the result is held in OUT until Dataout_ready.
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic [EXP_W+MAN_W:0] Datain1,
    input  logic [EXP_W+MAN_W:0] Datain2,
    input  logic                 Op,
    input  logic [1:0]           Rnd_mode,
    input  logic                 Data_valid,
    output logic                 In_ready,
    output logic [EXP_W+MAN_W:0] Dataout,
    output logic [3:0]           Exc,
    output logic                 Dataout_valid,
    input  logic                 Dataout_ready,
    output logic [2:0]           Debug
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 4;
    localparam int EP = EXP_W + 2;
    localparam logic [1:0] RNE = 2'd0, RTZ = 2'd1, RUP = 2'd2, RDN = 2'd3;
    localparam logic [2:0] S_IDLE = 3'd0, S_ALIGN = 3'd1, S_ADD = 3'd2,
                           S_NORM = 3'd3, S_ROUND = 3'd4, S_OUT = 3'd5;
    localparam logic [EXP_W-1:0] E_ONES = {EXP_W{1'b1}};
    localparam logic [W-1:0] QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-2:0] INF_M = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
    localparam logic [W-2:0] MAX_M = {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

    logic [2:0]     state;
    logic [W-1:0]   a_r, b_r;
    logic           op_r;
    logic [1:0]     rnd_r;
    logic           sgn_r, sub_r, zneg_r, zero_r;
    logic [EP-1:0]  exp_r;
    logic [SW-1:0]  l_sig, s_sig, n_r;
    logic [SW:0]    sum_r;

    assign In_ready = RSTn && (state == S_IDLE);
    assign Debug    = state;

    logic              sa, sb, nan_a, nan_b, inf_a, inf_b, a_ge;
    logic [EXP_W-1:0]  ea, eb, el, es, kl, ks;
    logic [MAN_W-1:0]  ma, mb;
    logic              spec_hit, spec_inv, stk;
    logic [W-1:0]      spec_res;
    logic [SW-1:0]     l_raw, s_raw, s_al;
    int                sh;

    assign sa    = a_r[W-1];
    assign sb    = b_r[W-1] ^ op_r;
    assign ea    = a_r[W-2:MAN_W];
    assign eb    = b_r[W-2:MAN_W];
    assign ma    = a_r[MAN_W-1:0];
    assign mb    = b_r[MAN_W-1:0];
    assign nan_a = (ea == E_ONES) && (|ma);
    assign nan_b = (eb == E_ONES) && (|mb);
    assign inf_a = (ea == E_ONES) && !(|ma);
    assign inf_b = (eb == E_ONES) && !(|mb);
    assign a_ge  = a_r[W-2:0] >= b_r[W-2:0];

    always_comb begin
        spec_hit = 1'b1;
        spec_inv = 1'b0;
        spec_res = QNAN;
        if (nan_a || nan_b)
            spec_inv = (nan_a && !ma[MAN_W-1]) || (nan_b && !mb[MAN_W-1]);
        else if (inf_a && inf_b && (sa != sb))
            spec_inv = 1'b1;
        else if (inf_a)
            spec_res = {sa, INF_M};
        else if (inf_b)
            spec_res = {sb, INF_M};
        else
            spec_hit = 1'b0;
    end

    // Smaller operand is shifted right; everything past the round bit collapses into sticky.
    always_comb begin
        el    = a_ge ? ea : eb;
        es    = a_ge ? eb : ea;
        kl    = (|el) ? el : EXP_W'(1);
        ks    = (|es) ? es : EXP_W'(1);
        l_raw = a_ge ? {|ea, ma, 3'b000} : {|eb, mb, 3'b000};
        s_raw = a_ge ? {|eb, mb, 3'b000} : {|ea, ma, 3'b000};
        sh    = int'(kl) - int'(ks);
        if (sh > MAN_W + 3)
            sh = MAN_W + 3;
        stk = 1'b0;
        for (int i = 0; i < SW; i++)
            if (i < sh)
                stk = stk | s_raw[i];
        s_al = (s_raw >> sh) | {{(SW-1){1'b0}}, stk};
    end

    logic [SW:0] sum;
    assign sum = sub_r ? ({1'b0, l_sig} - {1'b0, s_sig}) : ({1'b0, l_sig} + {1'b0, s_sig});

    logic [SW-1:0] n_nx;
    logic [EP-1:0] e_nx;
    int            lzc, lsh;

    // Left normalisation never takes the exponent below 1; a residue without hidden bit is subnormal.
    always_comb begin
        lzc = SW;
        for (int i = 0; i < SW; i++)
            if (sum_r[i])
                lzc = SW - 1 - i;
        lsh = (lzc < int'(exp_r) - 1) ? lzc : int'(exp_r) - 1;
        if (sum_r[SW]) begin
            n_nx = {sum_r[SW:2], sum_r[1] | sum_r[0]};
            e_nx = exp_r + EP'(1);
        end else begin
            n_nx = sum_r[SW-1:0] << lsh;
            e_nx = exp_r - EP'(lsh);
        end
    end

    logic [MAN_W+1:0] rsum;
    logic [EP-1:0]    e_f;
    logic [MAN_W-1:0] m_f;
    logic             inx, inc, hid, ovf;
    logic [W-1:0]     rnd_res;
    logic [3:0]       rnd_exc;

    always_comb begin
        inx = |n_r[2:0];
        case (rnd_r)
            RNE:     inc = n_r[2] & (n_r[1] | n_r[0] | n_r[3]);
            RTZ:     inc = 1'b0;
            RUP:     inc = !sgn_r & inx;
            default: inc = sgn_r & inx;
        endcase
        rsum = {1'b0, n_r[SW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
        if (rsum[MAN_W+1]) begin
            e_f = exp_r + EP'(1);
            m_f = rsum[MAN_W:1];
            hid = 1'b1;
        end else begin
            e_f = exp_r;
            m_f = rsum[MAN_W-1:0];
            hid = rsum[MAN_W];
        end
        ovf     = e_f >= {2'b00, E_ONES};
        rnd_exc = {2'b00, !hid & inx, inx};
        rnd_res = {sgn_r, hid ? e_f[EXP_W-1:0] : {EXP_W{1'b0}}, m_f};
        if (zero_r) begin
            rnd_exc = 4'b0000;
            rnd_res = {zneg_r | (rnd_r == RDN), {(W-1){1'b0}}};
        end else if (ovf) begin
            rnd_exc = 4'b0101;
            case (rnd_r)
                RNE:     rnd_res = {sgn_r, INF_M};
                RTZ:     rnd_res = {sgn_r, MAX_M};
                RUP:     rnd_res = sgn_r ? {1'b1, MAX_M} : {1'b0, INF_M};
                default: rnd_res = sgn_r ? {1'b1, INF_M} : {1'b0, MAX_M};
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state         <= S_IDLE;
            a_r           <= '0;
            b_r           <= '0;
            op_r          <= 1'b0;
            rnd_r         <= RNE;
            sgn_r         <= 1'b0;
            sub_r         <= 1'b0;
            zneg_r        <= 1'b0;
            zero_r        <= 1'b0;
            exp_r         <= '0;
            l_sig         <= '0;
            s_sig         <= '0;
            n_r           <= '0;
            sum_r         <= '0;
            Dataout       <= '0;
            Exc           <= 4'b0000;
            Dataout_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (Data_valid) begin
                    a_r   <= Datain1;
                    b_r   <= Datain2;
                    op_r  <= Op;
                    rnd_r <= Rnd_mode;
                    state <= S_ALIGN;
                end
                S_ALIGN: if (spec_hit) begin
                    Dataout <= spec_res;
                    Exc     <= {spec_inv, 3'b000};
                    state   <= S_OUT;
                end else begin
                    sgn_r  <= a_ge ? sa : sb;
                    sub_r  <= sa ^ sb;
                    zneg_r <= sa & sb;
                    exp_r  <= {2'b00, kl};
                    l_sig  <= l_raw;
                    s_sig  <= s_al;
                    state  <= S_ADD;
                end
                S_ADD: begin
                    sum_r <= sum;
                    state <= S_NORM;
                end
                S_NORM: begin
                    n_r    <= n_nx;
                    exp_r  <= e_nx;
                    zero_r <= ~|sum_r;
                    state  <= S_ROUND;
                end
                S_ROUND: begin
                    Dataout <= rnd_res;
                    Exc     <= rnd_exc;
                    state   <= S_OUT;
                end
                S_OUT: if (!Dataout_valid) begin
                    Dataout_valid <= 1'b1;
                end else if (Dataout_ready) begin
                    Dataout_valid <= 1'b0;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Bench for fp_addsub_seq (binary32): directed corner cases plus random ops against an exact-arithmetic model.
module tb_fp_addsub_seq;
    typedef logic [299:0] big_t;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic [31:0] Datain1, Datain2, Dataout;
    logic        Op, Data_valid, In_ready, Dataout_valid, Dataout_ready;
    logic [1:0]  Rnd_mode;
    logic [3:0]  Exc;
    logic [2:0]  Debug;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 CLK = ~CLK;

    fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .CLK(CLK), .RSTn(RSTn), .Datain1(Datain1), .Datain2(Datain2), .Op(Op),
        .Rnd_mode(Rnd_mode), .Data_valid(Data_valid), .In_ready(In_ready),
        .Dataout(Dataout), .Exc(Exc), .Dataout_valid(Dataout_valid),
        .Dataout_ready(Dataout_ready), .Debug(Debug)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    // Exact rational sum on a wide integer grid, then rounded to binary32.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic o,
                                  input logic [1:0] rm, output logic [31:0] r, output logic [3:0] x);
        logic sa, sb, s, inex, inc, nan_a, nan_b;
        int   ka, kb, emin, p, e, drop;
        big_t va, vb, mag, sig, rem, half, one;
        sa = a[31];
        sb = b[31] ^ o;
        r = 32'h0;
        x = 4'h0;
        one = 1;
        nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        if (nan_a || nan_b) begin
            r = 32'h7FC00000;
            x[3] = (nan_a && !a[22]) || (nan_b && !b[22]);
            return;
        end
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && sa != sb) begin
                r = 32'h7FC00000;
                x = 4'b1000;
            end else if (a[30:23] == 8'hFF) r = {sa, 8'hFF, 23'h0};
            else r = {sb, 8'hFF, 23'h0};
            return;
        end
        va = '0; va[23:0] = {a[30:23] != 0, a[22:0]};
        vb = '0; vb[23:0] = {b[30:23] != 0, b[22:0]};
        ka = (a[30:23] == 0) ? 1 : int'(a[30:23]);
        kb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
        emin = (ka < kb) ? ka : kb;
        va = va << (ka - emin);
        vb = vb << (kb - emin);
        if (sa == sb) begin mag = va + vb; s = sa; end
        else if (va >= vb) begin mag = va - vb; s = sa; end
        else begin mag = vb - va; s = sb; end
        if (mag == 0) begin
            r = {(sa && sb) || (rm == 2'd3), 31'h0};
            return;
        end
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = emin + p - 23;
        if (e < 1) e = 1;
        drop = e - emin;
        if (drop <= 0) begin sig = mag << (-drop); rem = 0; half = 0; end
        else begin sig = mag >> drop; rem = mag & ((one << drop) - one); half = one << (drop - 1); end
        inex = (rem != 0);
        case (rm)
            2'd0:    inc = (rem > half) || (inex && rem == half && sig[0]);
            2'd1:    inc = 1'b0;
            2'd2:    inc = !s && inex;
            default: inc = s && inex;
        endcase
        if (inc) sig = sig + one;
        if (sig[24]) begin sig = sig >> 1; e++; end
        if (e >= 255) begin
            x = 4'b0101;
            case (rm)
                2'd0:    r = {s, 8'hFF, 23'h0};
                2'd1:    r = {s, 31'h7F7FFFFF};
                2'd2:    r = s ? 32'hFF7FFFFF : 32'h7F800000;
                default: r = s ? 32'hFF800000 : 32'h7F7FFFFF;
            endcase
        end else begin
            r = {s, sig[23] ? 8'(e) : 8'h00, sig[22:0]};
            x = {2'b00, !sig[23] && inex, inex};
        end
    endfunction

    function automatic logic [31:0] gen(input logic [31:0] near);
        logic sg;
        sg = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
            0:       return $urandom();
            1:       return {sg, 8'h00, 23'($urandom())};
            2:       return {sg, 31'h0};
            3:       return {sg, 8'hFF, ($urandom_range(0, 1) == 1) ? 23'h0 : 23'($urandom())};
            4:       return {sg, 8'hFE, 23'($urandom())};
            5, 6:    return near ^ 32'($urandom_range(0, 255));
            default: return {sg, 8'($urandom_range(100, 140)), 23'($urandom())};
        endcase
    endfunction

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic o,
                          input logic [1:0] rm, input logic early, output int lat);
        int w;
        w = 0;
        while (!In_ready && w < 20) begin @(posedge CLK); #1; w++; end
        if (w == 20) chk("in_ready_timeout", {31'b0, In_ready}, 32'd1);
        Datain1 = a; Datain2 = b; Op = o; Rnd_mode = rm; Data_valid = 1'b1;
        @(posedge CLK); #1;
        Data_valid = 1'b0;
        Datain1 = $urandom(); Datain2 = $urandom(); Op = ~o; Rnd_mode = ~rm;
        Dataout_ready = early;
        lat = 0;
        while (!Dataout_valid && lat < 20) begin @(posedge CLK); #1; lat++; end
    endtask

    task automatic accept(input int hold);
        repeat (hold) begin @(posedge CLK); #1; end
        Dataout_ready = 1'b1;
        @(posedge CLK); #1;
        Dataout_ready = 1'b0;
    endtask

    task automatic dir(input string tag, input logic [31:0] a, input logic [31:0] b, input logic o,
                       input logic [1:0] rm, input logic [31:0] er, input logic [3:0] ex, input int el);
        int lat;
        launch(a, b, o, rm, 1'b0, lat);
        chk({tag, "_lat"}, lat, el);
        chk({tag, "_res"}, Dataout, er);
        chk({tag, "_exc"}, {28'b0, Exc}, {28'b0, ex});
        accept(0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b, er;
        logic [3:0]  ex;
        logic        o, seen;
        logic [1:0]  rm;
        int          lat;
        RSTn = 1'b0; Datain1 = '0; Datain2 = '0; Op = 1'b0; Rnd_mode = 2'd0;
        Data_valid = 1'b0; Dataout_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_in_ready", {31'b0, In_ready}, 32'd0);
        chk("rst_dout", Dataout, 32'h0);
        chk("rst_exc", {28'b0, Exc}, 32'h0);
        chk("rst_vld", {31'b0, Dataout_valid}, 32'd0);
        chk("rst_dbg", {29'b0, Debug}, 32'd0);
        RSTn = 1'b1;
        @(negedge CLK);
        chk("rdy_after_release", {31'b0, In_ready}, 32'd1);

        dir("one_plus_one",   32'h3F800000, 32'h3F800000, 1'b0, 2'd0, 32'h40000000, 4'b0000, 5);
        dir("one_m_one_rne",  32'h3F800000, 32'h3F800000, 1'b1, 2'd0, 32'h00000000, 4'b0000, 5);
        dir("one_m_one_rdn",  32'h3F800000, 32'h3F800000, 1'b1, 2'd3, 32'h80000000, 4'b0000, 5);
        dir("max_ovf_rne",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'd0, 32'h7F800000, 4'b0101, 5);
        dir("max_ovf_rtz",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'd1, 32'h7F7FFFFF, 4'b0101, 5);
        dir("inf_m_inf",      32'h7F800000, 32'hFF800000, 1'b0, 2'd0, 32'h7FC00000, 4'b1000, 2);
        dir("tie_rne",        32'h3F800000, 32'h33800000, 1'b0, 2'd0, 32'h3F800000, 4'b0001, 5);
        dir("tie_rup",        32'h3F800000, 32'h33800000, 1'b0, 2'd2, 32'h3F800001, 4'b0001, 5);
        dir("tie_rtz",        32'h3F800000, 32'h33800000, 1'b0, 2'd1, 32'h3F800000, 4'b0001, 5);
        dir("negz_plus_negz", 32'h80000000, 32'h80000000, 1'b0, 2'd0, 32'h80000000, 4'b0000, 5);

        // Subnormal result held under backpressure while new operands are offered.
        launch(32'h00000001, 32'h00000001, 1'b0, 2'd0, 1'b0, lat);
        chk("bp_lat", lat, 32'd5);
        Datain1 = 32'h40400000; Datain2 = 32'h40400000; Data_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge CLK); #1;
            chk("bp_hold_dout", Dataout, 32'h00000002);
            chk("bp_hold_exc", {28'b0, Exc}, 32'h0);
            chk("bp_hold_vld", {31'b0, Dataout_valid}, 32'd1);
            chk("bp_hold_rdy", {31'b0, In_ready}, 32'd0);
        end
        Data_valid = 1'b0;
        accept(0);
        chk("bp_vld_cleared", {31'b0, Dataout_valid}, 32'd0);
        chk("bp_idle_after", {31'b0, In_ready}, 32'd1);

        for (int i = 0; i < 400; i++) begin
            a  = gen($urandom());
            b  = gen(a);
            o  = 1'($urandom_range(0, 1));
            rm = 2'($urandom_range(0, 3));
            model(a, b, o, rm, er, ex);
            launch(a, b, o, rm, 1'($urandom_range(0, 1)), lat);
            chk($sformatf("rnd%0d_res a=%h b=%h op=%0d rm=%0d", i, a, b, o, rm), Dataout, er);
            chk($sformatf("rnd%0d_exc a=%h b=%h op=%0d rm=%0d", i, a, b, o, rm), {28'b0, Exc}, {28'b0, ex});
            chk($sformatf("rnd%0d_lat", i), lat,
                (a[30:23] == 8'hFF || b[30:23] == 8'hFF) ? 32'd2 : 32'd5);
            accept($urandom_range(0, 3));
        end

        // Reset while the op sits in ADD must drop it without a result.
        Datain1 = 32'h3F800000; Datain2 = 32'h3F800000; Op = 1'b0; Rnd_mode = 2'd0;
        Data_valid = 1'b1;
        @(posedge CLK); #1;
        Data_valid = 1'b0;
        @(posedge CLK); #1;
        chk("mid_dbg_add", {29'b0, Debug}, 32'd2);
        RSTn = 1'b0;
        #2;
        chk("mid_rst_vld", {31'b0, Dataout_valid}, 32'd0);
        chk("mid_rst_rdy", {31'b0, In_ready}, 32'd0);
        chk("mid_rst_dout", Dataout, 32'h0);
        chk("mid_rst_dbg", {29'b0, Debug}, 32'd0);
        @(posedge CLK); #1;
        RSTn = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge CLK); #1;
            if (Dataout_valid) seen = 1'b1;
        end
        chk("mid_no_result", {31'b0, seen}, 32'd0);
        chk("mid_rdy_after", {31'b0, In_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
